// File: rtl/seq_multiplier_param.sv
// Parametrised sequential shift-add multiplier with run-time signed/unsigned
// mode, a configurable result width with overflow detection, abort, and
// back-to-back launch from DONE. Latency is fixed at WIDTH+1 clocks.
module seq_multiplier_param #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 busy,
    output logic                 done,
    output logic                 negative,
    output logic                 overflow
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_FINISH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
    // which still fits because the magnitude is held as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic smode);
        if (smode && x[WIDTH-1]) begin
            magnitude = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = x;
        end
    endfunction

    // Two's-complement negate of the full product when the signs differ.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p,
                                                 input logic neg);
        if (neg) begin
            apply_sign = ~p + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            apply_sign = p;
        end
    endfunction

    // Signed: every bit from OUT_WIDTH-1 upward must equal the result MSB.
    // Unsigned: every bit from OUT_WIDTH upward must be zero.
    function automatic logic overflow_calc(input logic [PW-1:0] p,
                                           input logic smode);
        logic ovf;
        ovf = 1'b0;
        for (int i = OUT_WIDTH - 1; i < PW; i++) begin
            if (smode) begin
                if (p[i] != p[OUT_WIDTH-1]) begin
                    ovf = 1'b1;
                end else begin
                    ovf = ovf;
                end
            end else begin
                if ((i >= OUT_WIDTH) && p[i]) begin
                    ovf = 1'b1;
                end else begin
                    ovf = ovf;
                end
            end
        end
        overflow_calc = ovf;
    endfunction

    state_t               state_r, state_s;
    logic [PW-1:0]        acc_r, acc_s;
    logic [PW-1:0]        mcand_r, mcand_s;
    logic [WIDTH-1:0]     mplier_r, mplier_s;
    logic [CNT_W-1:0]     count_r, count_s;
    logic                 mode_r, mode_s;
    logic                 sign_a_r, sign_a_s;
    logic                 sign_b_r, sign_b_s;
    logic [OUT_WIDTH-1:0] result_r, result_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 negative_r, negative_s;
    logic                 overflow_r, overflow_s;
    logic                 negate_s;
    logic [PW-1:0]        product_s;
    logic [PW-1:0]        add_term_s;

    // Final signed product and the partial-product term for the current bit.
    always_comb begin
        negate_s   = mode_r & (sign_a_r ^ sign_b_r);
        product_s  = apply_sign(acc_r, negate_s);
        add_term_s = mplier_r[0] ? mcand_r : {PW{1'b0}};
    end

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        mcand_s    = mcand_r;
        mplier_s   = mplier_r;
        count_s    = count_r;
        mode_s     = mode_r;
        sign_a_s   = sign_a_r;
        sign_b_s   = sign_b_r;
        result_s   = result_r;
        busy_s     = busy_r;
        done_s     = done_r;
        negative_s = negative_r;
        overflow_s = overflow_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // abort is ignored here, so start wins when both are high
                if (start) begin
                    mode_s   = signed_mode;
                    sign_a_s = signed_mode & multiplicand[WIDTH-1];
                    sign_b_s = signed_mode & multiplier[WIDTH-1];
                    mcand_s  = {{WIDTH{1'b0}}, magnitude(multiplicand, signed_mode)};
                    mplier_s = magnitude(multiplier, signed_mode);
                    acc_s    = {PW{1'b0}};
                    count_s  = {CNT_W{1'b0}};
                    busy_s   = 1'b1;
                    done_s   = 1'b0;
                    state_s  = ST_BUSY;
                end else begin
                    state_s = state_r;
                end
            end
            ST_BUSY: begin
                if (abort) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    acc_s    = acc_r + add_term_s;
                    mcand_s  = {mcand_r[PW-2:0], 1'b0};
                    mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
                    if (count_r == CNT_W'(WIDTH - 1)) begin
                        count_s = {CNT_W{1'b0}};
                        state_s = ST_FINISH;
                    end else begin
                        count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_s = ST_BUSY;
                    end
                end
            end
            ST_FINISH: begin
                if (abort) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    result_s   = product_s[OUT_WIDTH-1:0];
                    negative_s = negate_s & (acc_r != {PW{1'b0}});
                    overflow_s = overflow_calc(product_s, mode_r);
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    state_s    = ST_DONE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                done_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            acc_r      <= {PW{1'b0}};
            mcand_r    <= {PW{1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            mode_r     <= 1'b0;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            result_r   <= {OUT_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            negative_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            acc_r      <= acc_s;
            mcand_r    <= mcand_s;
            mplier_r   <= mplier_s;
            count_r    <= count_s;
            mode_r     <= mode_s;
            sign_a_r   <= sign_a_s;
            sign_b_r   <= sign_b_s;
            result_r   <= result_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            negative_r <= negative_s;
            overflow_r <= overflow_s;
        end
    end

    assign result   = result_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign negative = negative_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Scoreboard bench for seq_multiplier_param: a full-width instance (8/16)
// and a narrow-result instance (8/12). Expected products are pushed when a
// launch is issued; a monitor pops and compares on each rising done.
module tb_seq_multiplier_param;

    logic        clock;
    logic        reset;
    logic        start_a, start_b;
    logic        abort_a, abort_b;
    logic        signed_mode;
    logic [7:0]  multiplicand, multiplier;
    logic [15:0] result_a;
    logic [11:0] result_b;
    logic        busy_a, done_a, negative_a, overflow_a;
    logic        busy_b, done_b, negative_b, overflow_b;
    logic        done_a_q, done_b_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        neg;
        logic        ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    seq_multiplier_param #(.WIDTH(8), .OUT_WIDTH(16)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .abort(abort_a),
        .signed_mode(signed_mode), .multiplicand(multiplicand), .multiplier(multiplier),
        .result(result_a), .busy(busy_a), .done(done_a),
        .negative(negative_a), .overflow(overflow_a)
    );

    seq_multiplier_param #(.WIDTH(8), .OUT_WIDTH(12)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .abort(abort_b),
        .signed_mode(signed_mode), .multiplicand(multiplicand), .multiplier(multiplier),
        .result(result_b), .busy(busy_b), .done(done_b),
        .negative(negative_b), .overflow(overflow_b)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare result/negative/overflow against the scoreboard on done rise.
    always @(negedge clock) begin
        if (done_a && !done_a_q) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL mon_a: unexpected done, result %0h", result_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                if ({result_a, negative_a, overflow_a} !== {e.res, e.neg, e.ovf}) begin
                    errors++;
                    $display("FAIL mon_a: got res %0h neg %0b ovf %0b expected res %0h neg %0b ovf %0b",
                             result_a, negative_a, overflow_a, e.res, e.neg, e.ovf);
                end
            end
        end
        if (done_b && !done_b_q) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL mon_b: unexpected done, result %0h", result_b);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                if ({4'h0, result_b, negative_b, overflow_b} !== {e.res, e.neg, e.ovf}) begin
                    errors++;
                    $display("FAIL mon_b: got res %0h neg %0b ovf %0b expected res %0h neg %0b ovf %0b",
                             result_b, negative_b, overflow_b, e.res, e.neg, e.ovf);
                end
            end
        end
        done_a_q <= done_a;
        done_b_q <= done_b;
    end

    task automatic push(input bit sel, input logic [15:0] res, input logic neg, input logic ovf);
        exp_t e;
        e.res = res;
        e.neg = neg;
        e.ovf = ovf;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    // Called at a negedge; pulses start across one rising edge (E0).
    task automatic drive_start(input bit sel, input logic m, input logic [7:0] a, input logic [7:0] b);
        signed_mode  = m;
        multiplicand = a;
        multiplier   = b;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Counts clocks after E0 until done, and the number of cycles busy was high.
    task automatic wait_done(input bit sel, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        for (int i = 0; i < 40; i++) begin
            if (sel ? done_b : done_a) break;
            if (sel ? busy_b : busy_a) bc++;
            lat++;
            @(negedge clock);
        end
        if (!(sel ? done_b : done_a)) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done not seen, got 0 expected 1");
        end
    endtask

    task automatic run(input bit sel, input logic m, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] res, input logic neg, input logic ovf);
        int lat, bc;
        push(sel, res, neg, ovf);
        drive_start(sel, m, a, b);
        wait_done(sel, lat, bc);
        check("latency", lat, 32'd9);
        check("busy_cycles", bc, 32'd9);
    endtask

    // Directed stimulus sequence.
    initial begin
        int lat, bc;
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        abort_a = 1'b0; abort_b = 1'b0;
        signed_mode = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
        done_a_q = 1'b0; done_b_q = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_result", {16'h0, result_a}, 32'h0);
        check("rst_flags", {28'h0, busy_a, done_a, negative_a, overflow_a}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Full-width instance: unsigned and signed products.
        run(1'b0, 1'b0, 8'hC8, 8'hFF, 16'hC738, 1'b0, 1'b0);
        run(1'b0, 1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b1, 1'b0);
        run(1'b0, 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0);
        run(1'b0, 1'b1, 8'hF9, 8'h00, 16'h0000, 1'b0, 1'b0);

        // Start while busy is ignored; operand changes after E0 have no effect.
        push(1'b0, 16'd42, 1'b0, 1'b0);
        drive_start(1'b0, 1'b0, 8'd6, 8'd7);
        @(negedge clock);
        @(negedge clock);
        multiplicand = 8'd1;
        multiplier   = 8'd1;
        start_a      = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        wait_done(1'b0, lat, bc);

        // Relaunch from DONE: done drops, old result held until new finish.
        push(1'b0, 16'd81, 1'b0, 1'b0);
        drive_start(1'b0, 1'b0, 8'd9, 8'd9);
        check("relaunch_done_low", {31'h0, done_a}, 32'h0);
        check("relaunch_hold", {16'h0, result_a}, 32'd42);
        wait_done(1'b0, lat, bc);
        check("relaunch_latency", lat, 32'd9);

        // Abort mid-operation keeps the last completed result.
        run(1'b0, 1'b0, 8'd12, 8'd12, 16'd144, 1'b0, 1'b0);
        drive_start(1'b0, 1'b0, 8'd5, 8'd5);
        @(negedge clock);
        @(negedge clock);
        abort_a = 1'b1;
        @(negedge clock);
        abort_a = 1'b0;
        check("abort_flags", {30'h0, busy_a, done_a}, 32'h0);
        check("abort_result", {16'h0, result_a}, 32'd144);
        repeat (12) @(negedge clock);
        check("abort_stays_idle", {30'h0, busy_a, done_a}, 32'h0);

        // Narrow-result instance: overflow against 12 bits.
        run(1'b1, 1'b1, 8'h64, 8'h32, 16'h0388, 1'b0, 1'b1);
        run(1'b1, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 1'b0, 1'b0);
        run(1'b1, 1'b1, 8'hC0, 8'h20, 16'h0800, 1'b1, 1'b0);

        // Asynchronous reset in the middle of an operation.
        drive_start(1'b0, 1'b0, 8'd3, 8'd4);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        check("async_rst_a", {result_a, 12'h0, busy_a, done_a, negative_a, overflow_a}, 32'h0);
        check("async_rst_b", {4'h0, result_b, 12'h0, busy_b, done_b, negative_b, overflow_b}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run(1'b0, 1'b0, 8'd10, 8'd11, 16'h006E, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        check("queue_a_empty", q_a.size(), 32'd0);
        check("queue_b_empty", q_b.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
